// File: rtl/rsa256_arbiter.sv
// Round-robin front end that lets two requesters share one RSA-256 core, with a watchdog abort.
// Accept at T -> core start at T+1, core finish at F -> response at F+1; an unaccepted response stalls new grants.
module rsa256_arbiter #(
  parameter int TIMEOUT = 1048576
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [1:0]   i_req_valid,
  output logic [1:0]   o_req_ready,
  input  logic [511:0] i_a,
  input  logic [511:0] i_e,
  input  logic [511:0] i_n,
  output logic [1:0]   o_resp_valid,
  input  logic [1:0]   i_resp_ready,
  output logic [255:0] o_resp_data,
  output logic         o_resp_err,
  output logic         o_core_start,
  output logic [255:0] o_core_a,
  output logic [255:0] o_core_e,
  output logic [255:0] o_core_n,
  input  logic [255:0] i_core_result,
  input  logic         i_core_finished,
  output logic         o_busy
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam logic [CW-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef struct packed {
    logic [255:0] a;
    logic [255:0] e;
    logic [255:0] n;
  } ops_t;

  state_t        state;
  state_t        state_nxt;
  ops_t          ops_q;
  ops_t          ops_in;
  logic          owner;
  logic          last;
  logic          grant;
  logic [CW-1:0] cnt;
  logic [255:0]  data_q;
  logic          err_q;
  logic          any_req;
  logic          xfer;
  logic          owner_ack;
  logic          finish;
  logic          expire;

  // last holds the requester served most recently; a tie goes to the other one
  always_comb begin
    grant = 1'b0;
    case (i_req_valid)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last;
      default: grant = 1'b0;
    endcase
  end

  always_comb begin
    ops_in.a = grant ? i_a[511:256] : i_a[255:0];
    ops_in.e = grant ? i_e[511:256] : i_e[255:0];
    ops_in.n = grant ? i_n[511:256] : i_n[255:0];
  end

  assign any_req   = |i_req_valid;
  assign xfer      = (state == IDLE) && any_req;
  assign owner_ack = (state == RESP) && i_resp_ready[owner];
  assign finish    = (state == WAIT) && i_core_finished;
  // a finish arriving on the last allowed cycle takes priority over the abort
  assign expire    = (state == WAIT) && (TIMEOUT > 0) && (cnt == CNT_LAST) && !i_core_finished;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = START;
      START:   state_nxt = WAIT;
      WAIT:    if (finish || expire) state_nxt = RESP;
      RESP:    if (owner_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ops_q  <= '0;
      owner  <= 1'b0;
      last   <= 1'b1;
      cnt    <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (xfer) begin
        ops_q <= ops_in;
        owner <= grant;
      end
      if (state == START) begin
        cnt <= '0;
      end else if ((state == WAIT) && (cnt != CNT_MAX)) begin
        cnt <= cnt + 1'b1;
      end
      if (finish) begin
        data_q <= i_core_result;
        err_q  <= 1'b0;
      end else if (expire) begin
        data_q <= '0;
        err_q  <= 1'b1;
      end
      if (owner_ack) last <= owner;
    end
  end

  // every output is forced low while reset is held, whatever the registers contain
  always_comb begin
    o_req_ready  = 2'b00;
    o_resp_valid = 2'b00;
    o_core_start = 1'b0;
    o_busy       = 1'b0;
    if (i_rst_n) begin
      case (state)
        IDLE: begin
          if (any_req) o_req_ready = grant ? 2'b10 : 2'b01;
        end
        START: begin
          o_core_start = 1'b1;
          o_busy       = 1'b1;
        end
        WAIT: begin
          o_busy = 1'b1;
        end
        RESP: begin
          o_busy       = 1'b1;
          o_resp_valid = owner ? 2'b10 : 2'b01;
        end
        default: begin
          o_busy = 1'b0;
        end
      endcase
    end
  end

  assign o_resp_data = i_rst_n ? data_q : '0;
  assign o_resp_err  = i_rst_n && (state == RESP) && err_q;
  assign o_core_a    = i_rst_n ? ops_q.a : '0;
  assign o_core_e    = i_rst_n ? ops_q.e : '0;
  assign o_core_n    = i_rst_n ? ops_q.n : '0;

endmodule

// File: tb/tb_rsa256_arbiter.sv
// Bench for rsa256_arbiter: three instances (default, TIMEOUT=8, TIMEOUT=4) share stimulus, one selected at a time.
module tb_rsa256_arbiter;

  logic         clk;
  logic         rst_n;
  logic [1:0]   req_valid;
  logic [1:0]   resp_ready;
  logic         core_finished;
  logic [255:0] core_result;
  logic [511:0] a;
  logic [511:0] e;
  logic [511:0] n;
  int           sel;

  logic [1:0]   rv_d   [3];
  logic [1:0]   rr_d   [3];
  logic         fin_d  [3];
  logic [1:0]   rdy_d  [3];
  logic [1:0]   vld_d  [3];
  logic [255:0] data_d [3];
  logic         err_d  [3];
  logic         start_d[3];
  logic [255:0] ca_d   [3];
  logic [255:0] ce_d   [3];
  logic [255:0] cn_d   [3];
  logic         busy_d [3];

  logic [1:0]   req_ready;
  logic [1:0]   resp_valid;
  logic [255:0] resp_data;
  logic         resp_err;
  logic         core_start;
  logic [255:0] core_a;
  logic [255:0] core_e;
  logic [255:0] core_n;
  logic         busy;

  int n_cmp;
  int n_err;

  int           tmo_tab[3];
  int           last_srv[3];
  logic [255:0] prev_a[3];
  logic [255:0] prev_e[3];
  logic [255:0] prev_n[3];

  rsa256_arbiter u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(rv_d[0]), .o_req_ready(rdy_d[0]),
    .i_a(a), .i_e(e), .i_n(n), .o_resp_valid(vld_d[0]), .i_resp_ready(rr_d[0]),
    .o_resp_data(data_d[0]), .o_resp_err(err_d[0]), .o_core_start(start_d[0]),
    .o_core_a(ca_d[0]), .o_core_e(ce_d[0]), .o_core_n(cn_d[0]),
    .i_core_result(core_result), .i_core_finished(fin_d[0]), .o_busy(busy_d[0])
  );

  rsa256_arbiter #(.TIMEOUT(8)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(rv_d[1]), .o_req_ready(rdy_d[1]),
    .i_a(a), .i_e(e), .i_n(n), .o_resp_valid(vld_d[1]), .i_resp_ready(rr_d[1]),
    .o_resp_data(data_d[1]), .o_resp_err(err_d[1]), .o_core_start(start_d[1]),
    .o_core_a(ca_d[1]), .o_core_e(ce_d[1]), .o_core_n(cn_d[1]),
    .i_core_result(core_result), .i_core_finished(fin_d[1]), .o_busy(busy_d[1])
  );

  rsa256_arbiter #(.TIMEOUT(4)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(rv_d[2]), .o_req_ready(rdy_d[2]),
    .i_a(a), .i_e(e), .i_n(n), .o_resp_valid(vld_d[2]), .i_resp_ready(rr_d[2]),
    .o_resp_data(data_d[2]), .o_resp_err(err_d[2]), .o_core_start(start_d[2]),
    .o_core_a(ca_d[2]), .o_core_e(ce_d[2]), .o_core_n(cn_d[2]),
    .i_core_result(core_result), .i_core_finished(fin_d[2]), .o_busy(busy_d[2])
  );

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      rv_d[k]  = (sel == k) ? req_valid : 2'b00;
      rr_d[k]  = (sel == k) ? resp_ready : 2'b00;
      fin_d[k] = (sel == k) && core_finished;
    end
    req_ready  = rdy_d[sel];
    resp_valid = vld_d[sel];
    resp_data  = data_d[sel];
    resp_err   = err_d[sel];
    core_start = start_d[sel];
    core_a     = ca_d[sel];
    core_e     = ce_d[sel];
    core_n     = cn_d[sel];
    busy       = busy_d[sel];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0b, expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // reference value the model core returns: a^e mod n by square-and-multiply
  function automatic logic [255:0] modexp(input longint unsigned b, input longint unsigned x,
                                          input longint unsigned m);
    longint unsigned r;
    longint unsigned bb;
    longint unsigned xx;
    r  = 1;
    bb = b % m;
    xx = x;
    while (xx != 0) begin
      if (xx[0]) r = (r * bb) % m;
      bb = (bb * bb) % m;
      xx = xx >> 1;
    end
    return 256'(r % m);
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      last_srv[k] = 1;
      prev_a[k]   = '0;
      prev_e[k]   = '0;
      prev_n[k]   = '0;
    end
  endfunction

  // One complete job on the selected instance; entered and left just after a rising edge.
  task automatic do_job(input logic [1:0] vld, input int delay, input int bp, input bit fixed);
    int           own;
    int           tmo;
    int           kend;
    bit           tout;
    logic [1:0]   obit;
    logic [255:0] res;
    logic [255:0] exp_d;
    int unsigned  oa[2];
    int unsigned  oe[2];
    int unsigned  on[2];

    tmo  = tmo_tab[sel];
    own  = (vld == 2'b01) ? 0 : (vld == 2'b10) ? 1 : 1 - last_srv[sel];
    obit = (own == 0) ? 2'b01 : 2'b10;
    for (int r = 0; r < 2; r++) begin
      oa[r] = $urandom_range(1000, 1);
      oe[r] = $urandom_range(40, 0);
      on[r] = $urandom_range(1000, 2);
    end
    if (fixed) begin
      oa[0] = 5;
      oe[0] = 3;
      on[0] = 33;
    end
    res   = modexp(longint'(oa[own]), longint'(oe[own]), longint'(on[own]));
    tout  = (delay > tmo);
    kend  = tout ? tmo : delay;
    exp_d = tout ? '0 : res;

    a             = {256'(oa[1]), 256'(oa[0])};
    e             = {256'(oe[1]), 256'(oe[0])};
    n             = {256'(on[1]), 256'(on[0])};
    req_valid     = vld;
    resp_ready    = 2'b00;
    core_finished = 1'b0;
    core_result   = rnd256();

    @(negedge clk);
    chk1("idle_busy", busy, 1'b0);
    chk2("grant", req_ready, obit);
    chkw("core_a_held", core_a, prev_a[sel]);
    chkw("core_n_held", core_n, prev_n[sel]);

    @(posedge clk); #1;
    @(negedge clk);
    chk1("start_pulse", core_start, 1'b1);
    chk2("start_no_ready", req_ready, 2'b00);
    chkw("core_a", core_a, 256'(oa[own]));
    chkw("core_e", core_e, 256'(oe[own]));
    chkw("core_n", core_n, 256'(on[own]));
    prev_a[sel] = 256'(oa[own]);
    prev_e[sel] = 256'(oe[own]);
    prev_n[sel] = 256'(on[own]);

    for (int k = 1; k <= kend; k++) begin
      @(posedge clk); #1;
      core_finished = (k == delay);
      core_result   = (k == delay) ? res : rnd256();
      @(negedge clk);
      chk1("wait_no_start", core_start, 1'b0);
      chk2("wait_no_valid", resp_valid, 2'b00);
    end

    @(posedge clk); #1;
    core_finished = 1'b0;
    core_result   = rnd256();
    @(negedge clk);
    chk2("resp_valid", resp_valid, obit);
    chkw("resp_data", resp_data, exp_d);
    chk1("resp_err", resp_err, tout);
    chk1("resp_busy", busy, 1'b1);
    chkw("resp_core_a_held", core_a, prev_a[sel]);

    for (int c = 0; c < bp; c++) begin
      resp_ready = ~obit;
      @(posedge clk); #1;
      core_result = rnd256();
      @(negedge clk);
      chk2("bp_valid", resp_valid, obit);
      chkw("bp_data", resp_data, exp_d);
      chk1("bp_err", resp_err, tout);
      chk2("bp_no_grant", req_ready, 2'b00);
    end

    resp_ready = obit | (2'($urandom) & ~obit);
    @(posedge clk); #1;
    resp_ready    = 2'b00;
    last_srv[sel] = own;

    if (tout) begin
      req_valid     = 2'b00;
      core_finished = 1'b1;
      core_result   = rnd256();
      @(posedge clk); #1;
      core_finished = 1'b0;
      @(negedge clk);
      chk2("late_finish_no_valid", resp_valid, 2'b00);
      chk1("late_finish_idle", busy, 1'b0);
      @(posedge clk); #1;
    end
  endtask

  // Start a job, hold reset low for one cycle while in WAIT, then pulse a stale finish.
  task automatic reset_mid(input int wcycles);
    req_valid     = 2'b01;
    a             = {rnd256(), rnd256()};
    e             = {rnd256(), rnd256()};
    n             = {rnd256(), rnd256()};
    resp_ready    = 2'b00;
    core_finished = 1'b0;
    @(posedge clk); #1;
    for (int w = 0; w < wcycles; w++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk1("mid_busy", busy, 1'b1);
    rst_n     = 1'b0;
    req_valid = 2'b11;
    #2;
    chk2("rst_req_ready", req_ready, 2'b00);
    chk2("rst_resp_valid", resp_valid, 2'b00);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_start", core_start, 1'b0);
    chkw("rst_core_a", core_a, '0);
    chkw("rst_core_e", core_e, '0);
    @(posedge clk); #1;
    rst_n         = 1'b1;
    req_valid     = 2'b00;
    core_finished = 1'b1;
    core_result   = rnd256();
    model_reset();
    @(negedge clk);
    chk1("post_rst_busy", busy, 1'b0);
    chkw("post_rst_core_n", core_n, '0);
    @(posedge clk); #1;
    core_finished = 1'b0;
    @(negedge clk);
    chk2("post_rst_finish_ignored", resp_valid, 2'b00);
    chk1("post_rst_idle", busy, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    n_cmp         = 0;
    n_err         = 0;
    tmo_tab[0]    = 1048576;
    tmo_tab[1]    = 8;
    tmo_tab[2]    = 4;
    model_reset();
    sel           = 0;
    rst_n         = 1'b0;
    req_valid     = 2'b11;
    resp_ready    = 2'b00;
    core_finished = 1'b0;
    core_result   = '0;
    a             = '0;
    e             = '0;
    n             = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk2("reset_req_ready", req_ready, 2'b00);
    chk2("reset_resp_valid", resp_valid, 2'b00);
    chk1("reset_resp_err", resp_err, 1'b0);
    chk1("reset_core_start", core_start, 1'b0);
    chk1("reset_busy", busy, 1'b0);
    chkw("reset_core_a", core_a, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // both requesters valid straight out of reset: served 0,1,0,1
    for (int j = 0; j < 4; j++) do_job(2'b11, 3, 0, 1'b0);

    // single job: 5^3 mod 33 returned after 10 WAIT cycles
    do_job(2'b01, 10, 0, 1'b1);

    // owner stalls the response for 5 cycles while both keep requesting
    do_job(2'b11, 2, 5, 1'b0);
    do_job(2'b10, 1, 0, 1'b0);

    // watchdog of 8: core never answers, then answers on exactly the 8th cycle
    sel = 1;
    do_job(2'b01, 30, 0, 1'b0);
    do_job(2'b10, 8, 0, 1'b0);

    // watchdog of 4: finish on the 4th WAIT cycle wins, then a plain abort
    sel = 2;
    do_job(2'b10, 4, 1, 1'b0);
    do_job(2'b01, 6, 2, 1'b0);

    // reset while waiting on the core, then a normal job
    sel = 1;
    reset_mid(3);
    do_job(2'b01, 2, 0, 1'b0);
    do_job(2'b11, 5, 1, 1'b0);

    for (int j = 0; j < 40; j++) begin
      int vs;
      sel = $urandom_range(2, 0);
      vs  = $urandom_range(3, 1);
      do_job(2'(vs), $urandom_range(12, 1), $urandom_range(3, 0), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
